// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - unified-memory request/ready bus between mc_ctrl and memory
interface mc_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] inst_in;

  modport master (output mem_req, output mem_we, input mem_ready, input inst_in);
  modport slave  (input mem_req, input mem_we, output mem_ready, output inst_in);
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control unit with IR and memory handshake
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   mem,
  input  logic        zero,
  output logic [25:0] inst_field,
  output logic        ALUSrc_A,
  output logic        ALUSrc_B,
  output logic [2:0]  ALU_Control,
  output logic [1:0]  Branch,
  output logic [1:0]  DatatoReg,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic        PCEN,
  output logic [2:0]  state,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_TRAP = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SRL  = 6'h02, FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic [5:0]  op, fn;
  logic        legal, dec_src_a, dec_src_b;
  logic [2:0]  dec_alu;
  logic        mem_req_c, mem_we_c;

  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // ALU setup derived from IR alone; only driven out in EX/MEM/WB.
  always_comb begin
    legal     = 1'b1;
    dec_alu   = ALU_AND;
    dec_src_a = 1'b0;
    dec_src_b = 1'b0;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADD: dec_alu = ALU_ADD;
          FN_SUB: dec_alu = ALU_SUB;
          FN_AND: dec_alu = ALU_AND;
          FN_OR:  dec_alu = ALU_OR;
          FN_XOR: dec_alu = ALU_XOR;
          FN_NOR: dec_alu = ALU_NOR;
          FN_SLT: dec_alu = ALU_SLT;
          FN_SRL: begin dec_alu = ALU_SRL; dec_src_a = 1'b1; end
          FN_JR:  ;
          default: legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_LUI: ;
      OP_BEQ, OP_BNE:       dec_alu = ALU_SUB;
      OP_ADDI:              begin dec_alu = ALU_ADD; dec_src_b = 1'b1; end
      OP_SLTI:              begin dec_alu = ALU_SLT; dec_src_b = 1'b1; end
      OP_ANDI:              begin dec_alu = ALU_AND; dec_src_b = 1'b1; end
      OP_ORI:               begin dec_alu = ALU_OR;  dec_src_b = 1'b1; end
      OP_LW, OP_SW:         begin dec_alu = ALU_ADD; dec_src_b = 1'b1; end
      default:              legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ALUSrc_A    = 1'b0;
    ALUSrc_B    = 1'b0;
    ALU_Control = ALU_AND;
    Branch      = 2'b00;
    DatatoReg   = 2'b00;
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    PCEN        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_RST: state_d = S_IF;
      S_IF: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_d    = mem.inst_in;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (!legal) begin
          state_d = S_TRAP;
        end else if (op == OP_J || op == OP_JAL) begin
          PCEN    = 1'b1;
          Branch  = 2'b10;
          state_d = S_IF;
          if (op == OP_JAL) begin
            RegWrite  = 1'b1;
            RegDst    = 2'b10;
            DatatoReg = 2'b11;
          end
        end else if (op == OP_R && fn == FN_JR) begin
          PCEN    = 1'b1;
          Branch  = 2'b11;
          state_d = S_IF;
        end else if (op == OP_LUI) begin
          state_d = S_WB;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        ALUSrc_A    = dec_src_a;
        ALUSrc_B    = dec_src_b;
        ALU_Control = dec_alu;
        if (op == OP_BEQ || op == OP_BNE) begin
          PCEN    = 1'b1;
          Branch  = (zero ^ (op == OP_BNE)) ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ALUSrc_A    = dec_src_a;
        ALUSrc_B    = dec_src_b;
        ALU_Control = dec_alu;
        mem_req_c   = 1'b1;
        mem_we_c    = (op == OP_SW);
        if (mem.mem_ready) begin
          PCEN    = 1'b1;
          state_d = S_IF;
          if (op == OP_LW) begin
            RegWrite  = 1'b1;
            DatatoReg = 2'b01;
          end
        end
      end
      S_WB: begin
        ALUSrc_A    = dec_src_a;
        ALUSrc_B    = dec_src_b;
        ALU_Control = dec_alu;
        RegWrite    = 1'b1;
        PCEN        = 1'b1;
        RegDst      = (op == OP_R) ? 2'b01 : 2'b00;
        DatatoReg   = (op == OP_LUI) ? 2'b10 : 2'b00;
        state_d     = S_IF;
      end
      S_TRAP: illegal = 1'b1;
      default: state_d = S_RST;
    endcase
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign state       = state_q;
  assign inst_field  = (state_q == S_RST || state_q == S_TRAP) ? 26'd0 : ir_q[25:0];

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed scoreboard bench for mc_ctrl
module tb_mc_ctrl;
  logic        clk;
  logic        rst;
  logic        zero;
  logic [25:0] inst_field;
  logic        ALUSrc_A, ALUSrc_B, RegWrite, PCEN, illegal;
  logic [2:0]  ALU_Control, state;
  logic [1:0]  Branch, DatatoReg, RegDst;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk(clk), .rst(rst), .mem(bus), .zero(zero), .inst_field(inst_field),
    .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control), .Branch(Branch),
    .DatatoReg(DatatoReg), .RegDst(RegDst), .RegWrite(RegWrite), .PCEN(PCEN),
    .state(state), .illegal(illegal)
  );

  localparam logic [2:0] ST_RST = 3'd0, ST_IF = 3'd1, ST_ID = 3'd2, ST_EX = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

  int          checks = 0;
  int          errors = 0;
  logic [25:0] cur_f;
  logic [44:0] exp_q[$];
  string       tag_q[$];
  logic [44:0] obs;

  assign obs = {state, bus.mem_req, bus.mem_we, ALUSrc_A, ALUSrc_B, ALU_Control, Branch,
                DatatoReg, RegDst, RegWrite, PCEN, illegal, inst_field};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [44:0] ev(input logic [2:0] st, input int mrq, input int mwe,
                                     input int sa, input int sb, input logic [2:0] alu,
                                     input logic [1:0] br, input logic [1:0] dtr,
                                     input logic [1:0] rd, input int rw, input int pc,
                                     input int ill, input logic [25:0] f);
    return {st, mrq[0], mwe[0], sa[0], sb[0], alu, br, dtr, rd, rw[0], pc[0], ill[0], f};
  endfunction

  function automatic logic [44:0] e_quiet(input logic [2:0] st, input logic [25:0] f);
    return ev(st, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, f);
  endfunction

  task automatic step(input int r, input int rdy, input logic [31:0] ins, input int z,
                      input logic [44:0] e, input string tag);
    logic [44:0] want;
    string       t;
    rst           = r[0];
    bus.mem_ready = rdy[0];
    bus.inst_in   = ins;
    zero          = z[0];
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, want);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] ins, input int waits);
    for (int i = 0; i < waits; i++)
      step(0, 0, 32'hDEAD_BEEF, 0, ev(ST_IF, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), "if_wait");
    step(0, 1, ins, 0, ev(ST_IF, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), "if_ready");
    cur_f = ins[25:0];
  endtask

  task automatic branch_op(input logic [31:0] ins, input int z, input logic [1:0] br, input string tag);
    fetch(ins, 0);
    step(0, 0, 32'h0, z, e_quiet(ST_ID, cur_f), "br_id");
    step(0, 0, 32'h0, z, ev(ST_EX, 0, 0, 0, 0, 3'b110, br, 2'b00, 2'b00, 0, 1, 0, cur_f), tag);
  endtask

  task automatic alu_op(input logic [31:0] ins, input logic [2:0] alu, input int sa, input int sb,
                        input logic [1:0] rd, input string tag);
    fetch(ins, 0);
    step(0, 0, 32'h0, 0, e_quiet(ST_ID, cur_f), "alu_id");
    step(0, 0, 32'h0, 0, ev(ST_EX, 0, 0, sa, sb, alu, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), tag);
    step(0, 0, 32'h0, 0, ev(ST_WB, 0, 0, sa, sb, alu, 2'b00, 2'b00, rd, 1, 1, 0, cur_f), tag);
  endtask

  initial begin
    rst = 1'b1; bus.mem_ready = 1'b1; bus.inst_in = 32'h0; zero = 1'b0; cur_f = 26'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(0, 1, 32'h0, 0, e_quiet(ST_RST, 26'd0), "reset_outputs");

    // add with fetch ready on the fourth IF cycle
    fetch(32'h0085_1020, 3);
    step(0, 0, 32'h0, 0, e_quiet(ST_ID, cur_f), "add_id");
    step(0, 0, 32'h0, 0, ev(ST_EX, 0, 0, 0, 0, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), "add_ex");
    step(0, 0, 32'h0, 0, ev(ST_WB, 0, 0, 0, 0, 3'b010, 2'b00, 2'b00, 2'b01, 1, 1, 0, cur_f), "add_wb");

    branch_op(32'h10A4_FFFF, 1, 2'b01, "beq_taken");
    branch_op(32'h10A4_FFFF, 0, 2'b00, "beq_not_taken");
    branch_op(32'h14A4_FFFF, 1, 2'b00, "bne_not_taken");
    branch_op(32'h14A4_FFFF, 0, 2'b01, "bne_taken");

    // lw with two memory wait cycles; inst_in garbage must not reach IR
    fetch(32'h8C82_0004, 0);
    step(0, 0, 32'h0, 0, e_quiet(ST_ID, cur_f), "lw_id");
    step(0, 0, 32'h0, 0, ev(ST_EX, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), "lw_ex");
    for (int i = 0; i < 2; i++)
      step(0, 0, 32'hFFFF_FFFF, 0, ev(ST_MEM, 1, 0, 0, 1, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), "lw_mem_wait");
    step(0, 1, 32'hFFFF_FFFF, 0, ev(ST_MEM, 1, 0, 0, 1, 3'b010, 2'b00, 2'b01, 2'b00, 1, 1, 0, cur_f), "lw_mem_ready");

    fetch(32'hAC82_0004, 0);
    step(0, 0, 32'h0, 0, e_quiet(ST_ID, cur_f), "sw_id");
    step(0, 0, 32'h0, 0, ev(ST_EX, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), "sw_ex");
    step(0, 1, 32'hFFFF_FFFF, 0, ev(ST_MEM, 1, 1, 0, 1, 3'b010, 2'b00, 2'b00, 2'b00, 0, 1, 0, cur_f), "sw_mem_ready");

    fetch(32'h0C00_0010, 0);
    step(0, 0, 32'h0, 0, ev(ST_ID, 0, 0, 0, 0, 3'b000, 2'b10, 2'b11, 2'b10, 1, 1, 0, cur_f), "jal_id");
    fetch(32'h0800_0020, 0);
    step(0, 0, 32'h0, 0, ev(ST_ID, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 2'b00, 0, 1, 0, cur_f), "j_id");
    fetch(32'h03E0_0008, 0);
    step(0, 0, 32'h0, 0, ev(ST_ID, 0, 0, 0, 0, 3'b000, 2'b11, 2'b00, 2'b00, 0, 1, 0, cur_f), "jr_id");

    fetch(32'h3C01_1234, 0);
    step(0, 0, 32'h0, 0, e_quiet(ST_ID, cur_f), "lui_id");
    step(0, 0, 32'h0, 0, ev(ST_WB, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 2'b00, 1, 1, 0, cur_f), "lui_wb");

    alu_op(32'h2042_0001, 3'b010, 0, 1, 2'b00, "addi");
    alu_op(32'h2842_0005, 3'b111, 0, 1, 2'b00, "slti");
    alu_op(32'h3442_0001, 3'b001, 0, 1, 2'b00, "ori");
    alu_op(32'h0002_1042, 3'b101, 1, 0, 2'b01, "srl");
    alu_op(32'h0085_102A, 3'b111, 0, 0, 2'b01, "slt");

    // reset while a load waits on memory drops the request
    fetch(32'h8C82_0004, 0);
    step(0, 0, 32'h0, 0, e_quiet(ST_ID, cur_f), "rlw_id");
    step(0, 0, 32'h0, 0, ev(ST_EX, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), "rlw_ex");
    step(1, 0, 32'h0, 0, ev(ST_MEM, 1, 0, 0, 1, 3'b010, 2'b00, 2'b00, 2'b00, 0, 0, 0, cur_f), "rlw_mem");
    cur_f = 26'd0;
    step(0, 1, 32'h0, 0, e_quiet(ST_RST, 26'd0), "rlw_rst");

    fetch(32'hFC00_0000, 0);
    step(0, 0, 32'h0, 0, e_quiet(ST_ID, cur_f), "illegal_id");
    for (int i = 0; i < 20; i++)
      step(0, i % 2, 32'h0085_1020, i % 2, ev(ST_TRAP, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 1, 26'd0), "trap_hold");
    step(1, 1, 32'h0, 0, ev(ST_TRAP, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 1, 26'd0), "trap_rst");
    cur_f = 26'd0;
    step(0, 0, 32'h0, 0, e_quiet(ST_RST, 26'd0), "trap_to_rst");
    step(0, 0, 32'h0, 0, ev(ST_IF, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 26'd0), "post_trap_if");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
